// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for the IF/ID and ID/EX boundary.
// Detects load-use hazards, holds jumpClear across a multi-cycle flush after a
// taken jump, and freezes fetch on HALT until resume. It also keeps two
// saturating debug counters: stall cycles and accepted jumps.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_LAT     = 1,    // bubble cycles per load-use hazard (1..7)
  parameter int unsigned FLUSH_CYCLES = 1,    // jumpClear cycles per taken jump (1..3)
  parameter bit          R0_ZERO      = 1'b1, // r0 as a destination never hazards
  parameter int unsigned CNT_W        = 16    // event counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_areg,
  input  logic [2:0]       id_breg,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic             id_halt,
  input  logic [2:0]       ex_dest,
  input  logic             ex_is_load,
  input  logic             ex_regwrite,
  input  logic             jump_taken,
  input  logic             resume,
  output logic             pc_write,
  output logic             IF_IDstall,
  output logic             jumpClear,
  output logic             ID_EXflush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  // The first cycle of a stall or flush is spent in RUN, so cnt starts one short.
  localparam logic [2:0] STALL_INIT = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic match_a, match_b, dest_masked, load_use;
  logic jump_accept;
  logic stall_evt, flush_evt;

  // Load-use hazard between the instruction in ID and the load in EX.
  always_comb begin
    match_a     = id_uses_a && (ex_dest == id_areg);
    match_b     = id_uses_b && (ex_dest == id_breg);
    dest_masked = R0_ZERO && (ex_dest == 3'd0);
    // A double operand match is still one hazard: the OR collapses it.
    load_use    = ex_is_load && ex_regwrite && (match_a || match_b) && !dest_masked;
    // EX holds a bubble during FLUSH, so a jump indication there is stale.
    jump_accept = jump_taken && (state_q != S_FLUSH);
  end

  // State, remaining-cycle counter and debug counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic: jump beats load-use beats halt.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer
    // a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    if (jump_accept) begin
      flush_evt = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = S_FLUSH;
        cnt_d   = FLUSH_INIT;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (load_use) begin
            stall_evt = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = S_STALL;
              cnt_d   = STALL_INIT;
            end
          end else if (id_halt) begin
            state_d = S_HALT;
          end
        end
        S_STALL: begin
          stall_evt = 1'b1;
          cnt_d     = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = S_RUN;
        end
        S_FLUSH: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = S_RUN;
        end
        S_HALT: begin
          if (resume) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Saturating event counters; they hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Output decode. Reset forces a clear of IF/ID, which has no reset of its own.
  always_comb begin
    pc_write   = 1'b1;
    IF_IDstall = 1'b0;
    jumpClear  = 1'b0;
    ID_EXflush = 1'b0;
    halted     = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      IF_IDstall = 1'b1;
      jumpClear  = 1'b1;
      ID_EXflush = 1'b1;
    end else begin
      halted = (state_q == S_HALT);
      if (jump_accept) begin
        jumpClear  = 1'b1;
        ID_EXflush = 1'b1;
      end else begin
        case (state_q)
          S_RUN: begin
            if (load_use || id_halt) begin
              IF_IDstall = 1'b1;
              pc_write   = 1'b0;
              ID_EXflush = 1'b1;
            end
          end
          S_STALL: begin
            IF_IDstall = 1'b1;
            pc_write   = 1'b0;
            ID_EXflush = 1'b1;
          end
          S_FLUSH: begin
            jumpClear  = 1'b1;
            ID_EXflush = 1'b1;
          end
          S_HALT: begin
            // On resume the HALT sitting in IF/ID is dropped via the bubble.
            ID_EXflush = 1'b1;
            if (!resume) begin
              IF_IDstall = 1'b1;
              pc_write   = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule
